// File: rtl/pit_timer.sv
// pit_timer: memory-mapped programmable interval timer.
// Four word registers (CTRL, PRESET, COUNT, reserved) sit in a 16-byte window
// at BASE. COUNT is loaded from PRESET and counted down to zero, which raises a
// level interrupt, either once (one-shot) or every period (auto-reload).

module pit_timer #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CNT,
    INT
  } state_t;

  localparam logic [27:0] BASE_TAG = BASE[31:4];

  state_t      state;
  state_t      state_next;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic [31:0] count_next;
  logic        irq_flag;

  logic        hit;
  logic        ctrl_wr;
  logic        preset_wr;
  logic        ctrl_en;
  logic        auto_reload;
  logic        en_clear;
  logic        flag_set;
  logic        flag_clear;

  assign hit         = (addr[29:2] == BASE_TAG);
  assign ctrl_wr     = we && hit && (addr[1:0] == 2'd0);
  assign preset_wr   = we && hit && (addr[1:0] == 2'd1);
  assign ctrl_en     = ctrl[0];
  assign auto_reload = (ctrl[2:1] == 2'b01);
  assign irq         = irq_flag && ctrl[3];

  // Next-state and count logic; the FSM only requests EN/flag changes, the
  // register block below arbitrates them against CPU writes.
  always_comb begin
    state_next = state;
    count_next = count;
    en_clear   = 1'b0;
    flag_set   = 1'b0;
    flag_clear = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl_en) state_next = LOAD;
      end
      LOAD: begin
        count_next = preset;
        state_next = CNT;
      end
      CNT: begin
        if (!ctrl_en) begin
          state_next = IDLE;
        end else if (count == 32'd0) begin
          state_next = INT;
          flag_set   = 1'b1;
        end else begin
          count_next = count - 32'd1;
        end
      end
      INT: begin
        if (auto_reload) begin
          flag_clear = 1'b1;
          state_next = LOAD;
        end else begin
          en_clear   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and register update; a CPU CTRL write beats both the FSM's EN clear
  // and any flag set landing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      if (ctrl_wr) begin
        ctrl <= din[3:0];
      end else if (en_clear) begin
        ctrl[0] <= 1'b0;
      end
      if (preset_wr) begin
        preset <= din;
      end
      if (ctrl_wr) begin
        irq_flag <= 1'b0;
      end else if (flag_set) begin
        irq_flag <= 1'b1;
      end else if (flag_clear) begin
        irq_flag <= 1'b0;
      end
    end
  end

  // Read mux; anything outside the window or at the reserved offset reads 0.
  always_comb begin
    dout = 32'd0;
    if (hit) begin
      case (addr[1:0])
        2'd0:    dout = {28'd0, ctrl};
        2'd1:    dout = preset;
        2'd2:    dout = count;
        default: dout = 32'd0;
      endcase
    end
  end

endmodule

// File: doc/pit_timer.md
Name: pit_timer

Overview:
- Memory-mapped programmable interval timer on the CPU's data bus.
- Sits directly downstream of the pipelined CPU's M-stage memory access.
- The system bridge forwards store/load requests in the timer's address window; the timer returns read data the same cycle.
- Counts down from a software-loaded preset and raises a level interrupt request toward the CPU's exception logic.

Parameters:
- BASE, 32'h0000_7F00: base byte address of the 16-byte register window. Bits [3:0] are zero.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- addr  input  30  word address from bridge, i.e. byte address bits [31:2].
- we  input  1  write strobe; qualified by address hit.
- din  input  32  write data.
- dout  output  32  read data, combinational from addr and registers.
- irq  output  1  interrupt request, level.

Behaviour:
- Address hit: addr[29:2] == BASE[31:4]. Offset = addr[1:0].
  - Offset 0: CTRL.
  - Offset 1: PRESET.
  - Offset 2: COUNT, read-only.
  - Offset 3: reserved.
- CTRL fields:
  - [0] EN: count enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as 00.
  - [3] IM: interrupt mask, 1 = enabled.
  - [31:4] read as 0.
- Writes (we & hit):
  - CTRL: stores din[3:0] and clears irq_flag.
  - PRESET: stores din[31:0].
  - COUNT and reserved: ignored.
- dout:
  - Hit: the addressed register, zero-extended.
  - Reserved offset or no hit: 0.
  - Reads have no side effects.
- irq = irq_flag & CTRL.IM.
- Reset values: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE. Hence irq=0 and dout=0 for every reset-time read.
- Reset asserted mid-count returns everything to reset values at the next edge; no interrupt is generated.
- FSM states IDLE, LOAD, CNT, INT, evaluated each edge:
  - IDLE: EN=1 -> LOAD. Otherwise stay; COUNT holds.
  - LOAD: COUNT <= PRESET; -> CNT.
  - CNT: EN=0 -> IDLE, COUNT holds its value. COUNT==0 -> INT, irq_flag <= 1. Else COUNT <= COUNT-1, stay.
  - INT, MODE 00: CTRL.EN <= 0; -> IDLE; irq_flag stays 1 until a CTRL write or reset.
  - INT, MODE 01: irq_flag <= 0; -> LOAD. irq_flag is therefore high for exactly one cycle per period.
- Period, auto-reload with PRESET=P: P+3 cycles between irq pulses (LOAD + P+1 CNT cycles + INT).
- Simultaneous events:
  - CPU CTRL write in the same cycle as the INT-state clearing of EN: the CPU write wins (CTRL takes din[3:0]).
  - The flag clear from a CTRL write takes priority over a flag set in the same cycle.
- PRESET written during CNT affects only the next LOAD; the current COUNT is untouched.
- PRESET=0: LOAD gives COUNT=0; the next CNT cycle goes to INT (interrupt 2 cycles after LOAD).
- COUNT never wraps: the decrement is blocked at 0.

Test Plan:
- One-shot:
  - Stimulus: reset; write PRESET=3; write CTRL=0x9 at edge 0.
  - Response: edge1 LOAD; edge2 COUNT=3; edge5 COUNT=0; edge6 state INT, irq=1; edge7 IDLE, CTRL reads 0x8.
  - irq stays 1 until a CTRL write of 0x0, then irq=0 one cycle later.
- Auto-reload:
  - Stimulus: PRESET=2, CTRL=0xB.
  - Response: irq is a 1-cycle pulse every 5 cycles; COUNT sequence 2,1,0,(INT),(LOAD) repeats. Run 4 periods.
- Mask:
  - Stimulus: PRESET=1, CTRL=0x1 (IM=0).
  - Response: irq stays 0 throughout. Writing CTRL=0x8 afterwards still gives irq=0, because the write clears the flag.
- Pause and resume:
  - Stimulus: PRESET=10, start; at COUNT=6 write CTRL=0x8.
  - Response: COUNT holds 6. Rewrite CTRL=0x9 -> LOAD restarts from 10, not 6.
- Bus decode:
  - Stimulus: read BASE+0xC and BASE+0x10; write to COUNT address with 0x1234.
  - Response: dout=0 for both reads; COUNT is unchanged.
- Reset mid-count with PRESET=0:
  - Stimulus: assert reset while COUNT=4.
  - Response: all registers 0 and irq=0 at the next edge.
  - Then PRESET=0, CTRL=0x9 -> irq=1 three edges after the CTRL write.
